// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the register-access SPI master.
// Command encodings, FSM states and the wire byte-order swap.
package spi_reg_pkg;

    localparam logic [1:0] CMD_RD   = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_FAST = 2'b11;

    // Widest data word the byte swap handles.
    localparam int SWAP_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    // Reverse the byte order of the low nbytes bytes of w.
    function automatic logic [SWAP_W-1:0] byte_swap(
        input logic [SWAP_W-1:0] w,
        input int                nbytes
    );
        logic [SWAP_W-1:0] r;
        int                s;
        r = '0;
        for (int i = 0; i < SWAP_W/8; i++) begin
            s = nbytes - 1 - i;
            if (i < nbytes) begin
                r[8*i +: 8] = w[8*(s & 7) +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sclk_tick.sv
// sclk half-period divider: one tick every CLK_DIV enabled cycles.
// Dropping en freezes the phase, which stretches the current half-period.
module spi_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    // Free-running half-period counter, held while disabled.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_master.sv
// SPI master for the register-access slave: one command per frame.
// Define SPI_REG_MASTER_STATUS_EN to capture the command-phase status byte.
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int REG_W   = 8,
    parameter int LEN_W   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [5:0]       cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [REG_W-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [REG_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [7:0]       status_o,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             nss
);

    localparam int BW = $clog2(REG_W);
    localparam int NB = REG_W / 8;

    state_t           state;
    logic [1:0]       ctype;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] wcnt;
    logic [BW-1:0]    bcnt;
    logic             in_cmd;
    logic             stall;
    logic [REG_W-1:0] tx_sh;
    logic [REG_W-1:0] wr_buf;
    logic [REG_W-1:0] rx_sh;
    logic [REG_W-1:0] rx_next;
    logic [REG_W-1:0] wr_swap;
    logic [REG_W-1:0] rx_swap;
    logic             tick;
    logic             cmd_end;
    logic             word_end;

    assign rx_next  = {rx_sh[REG_W-2:0], miso};
    assign wr_swap  = REG_W'(byte_swap(SWAP_W'(wr_data), NB));
    assign rx_swap  = REG_W'(byte_swap(SWAP_W'(rx_next), NB));
    assign cmd_end  = in_cmd && (bcnt == BW'(7));
    assign word_end = !in_cmd && (bcnt == BW'(REG_W - 1));
    assign busy     = (state != IDLE);

    spi_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .en   (busy && !stall),
        .tick (tick)
    );

    // Frame sequencer: command byte, data words, hold and inter-frame gap.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            nss       <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            done      <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            ctype     <= CMD_RD;
            len_q     <= '0;
            wcnt      <= '0;
            bcnt      <= '0;
            in_cmd    <= 1'b0;
            stall     <= 1'b0;
            tx_sh     <= '0;
            wr_buf    <= '0;
            rx_sh     <= '0;
        end else begin
            done     <= 1'b0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_type == 2'b01) begin
                            done <= 1'b1;
                        end else if (cmd_type != CMD_WR || wr_valid) begin
                            ctype     <= cmd_type;
                            len_q     <= cmd_len;
                            tx_sh     <= REG_W'({cmd_type, cmd_addr}) << (REG_W - 8);
                            mosi      <= cmd_type[1];
                            nss       <= 1'b0;
                            cmd_ready <= 1'b0;
                            in_cmd    <= 1'b1;
                            bcnt      <= '0;
                            wcnt      <= '0;
                            state     <= SETUP;
                            if (cmd_type == CMD_WR) begin
                                wr_ready <= 1'b1;
                                wr_buf   <= wr_swap;
                            end
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        rx_sh <= rx_next;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (stall) begin
                        if (wr_valid) begin
                            stall    <= 1'b0;
                            wr_ready <= 1'b1;
                            tx_sh    <= wr_swap;
                            mosi     <= wr_swap[REG_W-1];
                        end
                    end else if (tick && !sclk) begin
                        sclk  <= 1'b1;
                        rx_sh <= rx_next;
                        if (word_end && ctype == CMD_RD) begin
                            rd_data  <= rx_swap;
                            rd_valid <= 1'b1;
                        end
                    end else if (tick) begin
                        sclk <= 1'b0;
                        if (cmd_end) begin
                            if (ctype == CMD_FAST) begin
                                state <= HOLD;
                            end else begin
                                in_cmd <= 1'b0;
                                bcnt   <= '0;
                                tx_sh  <= (ctype == CMD_WR) ? wr_buf : '0;
                                mosi   <= (ctype == CMD_WR) && wr_buf[REG_W-1];
                            end
                        end else if (word_end) begin
                            if (wcnt == len_q) begin
                                state <= HOLD;
                            end else begin
                                wcnt <= wcnt + 1'b1;
                                bcnt <= '0;
                                if (ctype == CMD_WR && wr_valid) begin
                                    wr_ready <= 1'b1;
                                    tx_sh    <= wr_swap;
                                    mosi     <= wr_swap[REG_W-1];
                                end else if (ctype == CMD_WR) begin
                                    stall <= 1'b1;
                                end else begin
                                    tx_sh <= '0;
                                    mosi  <= 1'b0;
                                end
                            end
                        end else begin
                            bcnt  <= bcnt + 1'b1;
                            tx_sh <= tx_sh << 1;
                            mosi  <= tx_sh[REG_W-2];
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        nss   <= 1'b1;
                        mosi  <= 1'b0;
                        done  <= 1'b1;
                        bcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (bcnt == BW'(1)) begin
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SPI_REG_MASTER_STATUS_EN
    logic [7:0] status_q;
    logic       cap_status;

    assign cap_status = (state == SHIFT) && !stall && tick && !sclk && cmd_end;
    assign status_o   = status_q;

    // Latch the slave status shifted out against the command byte.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            status_q <= 8'h00;
        end else if (cap_status) begin
            status_q <= rx_next[7:0];
        end
    end
`else
    assign status_o = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Randomised bench for spi_reg_master at REG_W=8 and REG_W=16.
// A wire-level slave model supplies miso and records mosi per frame.
module tb_spi_reg_master;
    import spi_reg_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'b00;
    logic [5:0]  cmd_addr = 6'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_valid = 1'b0;
    logic        miso = 1'b0;

    logic        cr8, wrr8, rdv8, busy8, done8, sclk8, mosi8, nss8;
    logic [7:0]  rd8, st8;
    logic        cr16, wrr16, rdv16, busy16, done16, sclk16, mosi16, nss16;
    logic [15:0] rd16;
    logic [7:0]  st16;

    spi_reg_master #(.REG_W(8), .LEN_W(4), .CLK_DIV(4)) u_dut8 (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid && !sel), .cmd_ready(cr8),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data[7:0]), .wr_valid(wr_valid && !sel), .wr_ready(wrr8),
        .rd_data(rd8), .rd_valid(rdv8), .status_o(st8),
        .busy(busy8), .done(done8),
        .sclk(sclk8), .mosi(mosi8), .miso(miso), .nss(nss8)
    );

    spi_reg_master #(.REG_W(16), .LEN_W(4), .CLK_DIV(4)) u_dut16 (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid && sel), .cmd_ready(cr16),
        .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid && sel), .wr_ready(wrr16),
        .rd_data(rd16), .rd_valid(rdv16), .status_o(st16),
        .busy(busy16), .done(done16),
        .sclk(sclk16), .mosi(mosi16), .miso(miso), .nss(nss16)
    );

    logic        cr_s, wrr_s, rdv_s, busy_s, done_s, sclk_s, mosi_s, nss_s;
    logic [15:0] rd_s;
    logic [7:0]  st_s;
    assign cr_s   = sel ? cr16   : cr8;
    assign wrr_s  = sel ? wrr16  : wrr8;
    assign rdv_s  = sel ? rdv16  : rdv8;
    assign busy_s = sel ? busy16 : busy8;
    assign done_s = sel ? done16 : done8;
    assign sclk_s = sel ? sclk16 : sclk8;
    assign mosi_s = sel ? mosi16 : mosi8;
    assign nss_s  = sel ? nss16  : nss8;
    assign rd_s   = sel ? rd16   : {8'h00, rd8};
    assign st_s   = sel ? st16   : st8;

    logic [15:0] regs [64];
    logic [15:0] wq [3];
    logic [7:0]  status_b;
    bit          miso_q[$];
    bit          mosi_exp[$];
    bit          mosi_cap[$];
    logic [15:0] rd_exp[$];
    logic [15:0] rd_got[$];
    int          rises, dones, wrrs, nss_falls, mi_idx;
    bit          sclk_p = 1'b0;
    bit          nss_p = 1'b1;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Append a word to a bit stream: bytes LSB first, MSB first in a byte.
    function automatic void add_word(input logic [15:0] w, input int wbits, input bit to_miso);
        for (int b = 0; b < wbits / 8; b++) begin
            for (int i = 7; i >= 0; i--) begin
                if (to_miso) miso_q.push_back(w[8*b+i]);
                else mosi_exp.push_back(w[8*b+i]);
            end
        end
    endfunction

    // Slave side: shift miso on sclk fall, record mosi on sclk rise.
    always @(negedge clk) begin
        if (nss_p && !nss_s) begin
            nss_falls++;
            mi_idx = 0;
        end
        if (!sclk_p && sclk_s) begin
            mosi_cap.push_back(mosi_s);
            rises++;
        end
        if (sclk_p && !sclk_s) mi_idx++;
        miso = (!nss_s && mi_idx < miso_q.size()) ? miso_q[mi_idx] : 1'b0;
        if (rdv_s) rd_got.push_back(rd_s);
        if (done_s) dones++;
        if (wrr_s) wrrs++;
        sclk_p = sclk_s;
        nss_p = nss_s;
    end

    task automatic frame(input logic [1:0] t, input logic [5:0] a, input int len,
                         input int stall_cyc, input int rst_at);
        int W, nw, idx, nc, st_n, st_r, cyc;
        bit isrd, iswr, isfast, bad, waiting, stalling, hi, timed_out;
        logic [15:0] mask, v;
        logic [63:0] pg, pe;
        W = sel ? 16 : 8;
        mask = sel ? 16'hFFFF : 16'h00FF;
        isrd = (t == CMD_RD);
        iswr = (t == CMD_WR);
        isfast = (t == CMD_FAST);
        bad = (t == 2'b01);
        nw = (isrd || iswr) ? len + 1 : 0;
        miso_q.delete(); mosi_exp.delete(); mosi_cap.delete();
        rd_exp.delete(); rd_got.delete();
        rises = 0; dones = 0; wrrs = 0; nss_falls = 0;
        add_word({8'h00, status_b}, 8, 1);
        add_word({8'h00, t, a}, 8, 0);
        for (int i = 0; i < nw; i++) begin
            if (isrd) begin
                v = regs[(int'(a) + i) % 64] & mask;
                add_word(v, W, 1);
                rd_exp.push_back(v);
            end else begin
                add_word(wq[i] & mask, W, 0);
            end
        end
        cmd_type = t; cmd_addr = a; cmd_len = 4'(len); cmd_valid = 1'b1;
        idx = 0; waiting = 0; stalling = 0; hi = 0; st_n = 0; st_r = 0;
        wr_data = wq[0]; wr_valid = iswr;
        timed_out = 1'b1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #1;
            if (busy_s || done_s) cmd_valid = 1'b0;
            if (iswr && wrr_s) begin
                idx++;
                if (idx < nw) wr_data = wq[idx];
                waiting = (stall_cyc > 0 && idx == 1);
                if (idx >= nw || waiting) wr_valid = 1'b0;
            end
            if (waiting && !stalling && rises == 8 + W && !sclk_s) begin
                stalling = 1; st_n = 0; st_r = rises; hi = 0;
            end else if (stalling) begin
                if (sclk_s) hi = 1;
                st_n++;
                if (st_n >= stall_cyc) begin
                    chk("stall_edges", rises, st_r);
                    chk("stall_sclk", hi, 0);
                    chk("stall_wrr", wrrs, 1);
                    stalling = 0; waiting = 0; wr_valid = 1'b1;
                end
            end
            if (rst_at > 0 && rises >= rst_at) begin
                nrst = 1'b0;
                @(negedge clk); #1;
                chk("rst_mid_nss", nss_s, 1);
                chk("rst_mid_sclk", sclk_s, 0);
                repeat (4) @(negedge clk);
                #1;
                chk("rst_mid_done", dones, 0);
                cmd_valid = 1'b0; wr_valid = 1'b0; nrst = 1'b1;
                @(negedge clk); #1;
                chk("rst_mid_ready", cr_s, 1);
                return;
            end
            if (dones > 0 && cr_s) begin
                timed_out = 1'b0;
                break;
            end
        end
        cmd_valid = 1'b0; wr_valid = 1'b0;
        chk("frame_end", timed_out, 0);
        chk("rises", rises, bad ? 0 : (isfast ? 8 : 8 + nw * W));
        chk("nss_falls", nss_falls, bad ? 0 : 1);
        chk("done", dones, 1);
        chk("wr_ready", wrrs, iswr ? nw : 0);
        nc = iswr ? 8 + nw * W : (bad ? 0 : 8);
        pg = '0; pe = '0;
        for (int i = 0; i < nc; i++) begin
            pe = {pe[62:0], mosi_exp[i]};
            pg = {pg[62:0], (i < mosi_cap.size()) ? logic'(mosi_cap[i]) : 1'bx};
        end
        chk("mosi", pg, pe);
        chk("rd_count", rd_got.size(), rd_exp.size());
        for (int i = 0; i < rd_exp.size(); i++)
            chk("rd_data", (i < rd_got.size()) ? rd_got[i] : 16'hxxxx, rd_exp[i]);
`ifdef SPI_REG_MASTER_STATUS_EN
        if (!bad) chk("status", st_s, status_b);
`else
        chk("status", st_s, 0);
`endif
    endtask

    logic [1:0] types [4];

    initial begin
        types[0] = CMD_RD; types[1] = CMD_WR; types[2] = CMD_FAST; types[3] = 2'b01;
        for (int i = 0; i < 64; i++) regs[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_nss", nss8, 1);
        chk("rst_sclk", sclk8, 0);
        chk("rst_mosi", mosi8, 0);
        chk("rst_ready", cr8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_flags", {done8, wrr8, rdv8}, 0);
        chk("rst_rd", rd8, 0);
        chk("rst_status", st8, 0);
        chk("rst16_nss", nss16, 1);
        nrst = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_rst", cr8, 1);

        status_b = 8'h3E; wq[0] = 16'h00A5;
        frame(CMD_WR, 6'd3, 0, 0, 0);
        regs[5] = 16'h005C;
        frame(CMD_RD, 6'd5, 0, 0, 0);
        regs[62] = 16'h0011; regs[63] = 16'h0022; regs[0] = 16'h0033;
        frame(CMD_RD, 6'd62, 2, 0, 0);
        frame(CMD_FAST, 6'h15, 0, 0, 0);
        frame(2'b01, 6'h2A, 0, 0, 0);
        wq[0] = 16'h00C3; wq[1] = 16'h005A;
        frame(CMD_WR, 6'd9, 1, 20, 19);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            @(negedge clk); #1;
            if (sel) begin
                status_b = 8'h81; wq[0] = 16'h1234;
                frame(CMD_WR, 6'd7, 0, 0, 0);
                regs[12] = 16'h5678;
                frame(CMD_RD, 6'd12, 0, 0, 0);
            end
            for (int k = 0; k < 6; k++) begin
                status_b = 8'($urandom);
                for (int i = 0; i < 3; i++) wq[i] = 16'($urandom);
                frame(types[$urandom_range(0, 3)], 6'($urandom),
                      $urandom_range(0, 2), 0, 0);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
